// File: rtl/backend_seq_ctrl_if.sv
// backend_seq_ctrl_if: serial config link and backend control bus of the receive-backend sequencer
interface backend_seq_ctrl_if;
  logic       i_sclk;
  logic       i_sdin;
  logic       o_ready;
  logic [1:0] o_gainA1;
  logic [2:0] o_gainA2;
  logic       o_resetbvco;
  logic       o_resetb1;
  logic       o_resetb2;
  logic       o_frame_err;
  modport master (
    output i_sclk, i_sdin,
    input  o_ready, o_gainA1, o_gainA2, o_resetbvco, o_resetb1, o_resetb2, o_frame_err
  );
  modport slave (
    input  i_sclk, i_sdin,
    output o_ready, o_gainA1, o_gainA2, o_resetbvco, o_resetb1, o_resetb2, o_frame_err
  );
endinterface

// File: rtl/backend_seq_ctrl.sv
// backend_seq_ctrl: deserialises the gain frame and releases VCO/stage-1/stage-2 resets in timed order
// BACKEND_SEQ_PARITY_EN switches to a 9-bit frame whose bit 0 is odd parity over the whole frame
module backend_seq_ctrl #(
  parameter int DLY_CYC = 16,
  parameter int GAP_CYC = 64
) (
  input  logic                i_clk,
  input  logic                i_resetbAll,
  backend_seq_ctrl_if.slave   bus
);
`ifdef BACKEND_SEQ_PARITY_EN
  localparam int FRAME_W = 9;
`else
  localparam int FRAME_W = 8;
`endif
  localparam int              GW       = $clog2(GAP_CYC + 1);
  localparam logic [3:0]      BIT_LAST = 4'(FRAME_W - 1);
  localparam logic [GW-1:0]   GAP_MAX  = GW'(GAP_CYC);
  localparam logic [7:0]      DLY_LD   = 8'(DLY_CYC - 1);
  typedef enum logic [2:0] {WAIT_CFG, SEQ_VCO, SEQ_1, SEQ_2, RUN} state_t;
  state_t               r_state;
  logic [1:0]           r_sclk_s, r_sdin_s;
  logic                 r_sclk_d, r_frame_done;
  logic [3:0]           r_bitcnt;
  logic [GW-1:0]        r_gap;
  logic [FRAME_W-1:0]   r_shift;
  logic [7:0]           r_dly;
  logic                 w_sclk_rise, w_gap_exp, w_ok, w_take;
  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_gap_exp   = r_gap == GAP_MAX;
`ifdef BACKEND_SEQ_PARITY_EN
  assign w_ok = (r_shift[FRAME_W-1 -: 3] == 3'b101) & (^r_shift);
`else
  assign w_ok = r_shift[FRAME_W-1 -: 3] == 3'b101;
`endif
  // frames completing while the resets are being sequenced are ignored entirely
  assign w_take = r_frame_done & (r_state == WAIT_CFG || r_state == RUN);
  always_ff @(posedge i_clk or negedge i_resetbAll)
    if (!i_resetbAll) begin
      r_sclk_s     <= '0;
      r_sdin_s     <= '0;
      r_sclk_d     <= 1'b0;
      r_frame_done <= 1'b0;
      r_bitcnt     <= '0;
      r_gap        <= '0;
      r_shift      <= '0;
    end else begin
      r_sclk_s     <= {r_sclk_s[0], bus.i_sclk};
      r_sdin_s     <= {r_sdin_s[0], bus.i_sdin};
      r_sclk_d     <= r_sclk_s[1];
      r_frame_done <= w_sclk_rise && r_bitcnt == BIT_LAST;
      r_gap        <= w_sclk_rise ? '0 : (w_gap_exp ? r_gap : r_gap + GW'(1));
      r_bitcnt     <= w_sclk_rise ? (r_bitcnt == BIT_LAST ? 4'd0 : r_bitcnt + 4'd1)
                                  : (w_gap_exp ? 4'd0 : r_bitcnt);
      if (w_sclk_rise) r_shift <= {r_shift[FRAME_W-2:0], r_sdin_s[1]};
    end
  always_ff @(posedge i_clk or negedge i_resetbAll)
    if (!i_resetbAll) begin
      r_state         <= WAIT_CFG;
      r_dly           <= '0;
      bus.o_ready     <= 1'b0;
      bus.o_gainA1    <= '0;
      bus.o_gainA2    <= '0;
      bus.o_resetbvco <= 1'b0;
      bus.o_resetb1   <= 1'b0;
      bus.o_resetb2   <= 1'b0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_frame_err <= w_take & ~w_ok;
      if (w_take && w_ok) begin
        bus.o_gainA1 <= r_shift[FRAME_W-4 -: 2];
        bus.o_gainA2 <= r_shift[FRAME_W-6 -: 3];
      end
      case (r_state)
        WAIT_CFG:
          if (w_take && w_ok) begin
            r_dly       <= DLY_LD;
            bus.o_ready <= 1'b0;
            r_state     <= SEQ_VCO;
          end else bus.o_ready <= 1'b1;
        SEQ_VCO:
          if (r_dly == 8'd0) begin
            bus.o_resetbvco <= 1'b1;
            r_dly           <= DLY_LD;
            r_state         <= SEQ_1;
          end else r_dly <= r_dly - 8'd1;
        SEQ_1:
          if (r_dly == 8'd0) begin
            bus.o_resetb1 <= 1'b1;
            r_dly         <= DLY_LD;
            r_state       <= SEQ_2;
          end else r_dly <= r_dly - 8'd1;
        SEQ_2:
          if (r_dly == 8'd0) begin
            bus.o_resetb2 <= 1'b1;
            bus.o_ready   <= 1'b1;
            r_state       <= RUN;
          end else r_dly <= r_dly - 8'd1;
        RUN:     r_state <= RUN;
        default: r_state <= WAIT_CFG;
      endcase
    end
endmodule

// File: tb/tb_backend_seq_ctrl.sv
// tb_backend_seq_ctrl: randomized scoreboard bench for backend_seq_ctrl
module tb_backend_seq_ctrl;
  localparam int DLY = 16;
`ifdef BACKEND_SEQ_PARITY_EN
  localparam int FW  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int FW  = 8;
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  backend_seq_ctrl_if bus();
  backend_seq_ctrl #(.DLY_CYC(DLY), .GAP_CYC(64)) dut (.i_clk(clk), .i_resetbAll(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [9:0] snap;
    int         gap;
    string      name;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [9:0] mon_s;
  logic [9:0] prev = '0;
  bit mon_on = 1'b0;
  int cyc = 0;
  int last_cyc = 0;
  // reference model: phase 0 = waiting for config, 1 = sequencing, 2 = running
  bit m_err, m_ready, m_vco, m_r1, m_r2;
  logic [1:0] m_g1;
  logic [2:0] m_g2;
  int m_phase = 0;
  function automatic logic [9:0] dut_snap();
    return {bus.o_frame_err, bus.o_ready, bus.o_resetbvco, bus.o_resetb1, bus.o_resetb2, bus.o_gainA1, bus.o_gainA2};
  endfunction
  function automatic logic [9:0] mpack();
    return {m_err, m_ready, m_vco, m_r1, m_r2, m_g1, m_g2};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input string n, input int g);
    q.push_back('{snap: mpack(), gap: g, name: n});
  endtask
  // each observed change of the output bundle must match the next expected snapshot
  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      mon_s = dut_snap();
      if (mon_s !== prev) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_change: got %0h expected %0h at %0t", mon_s, prev, $time);
        end else begin
          mon_e = q.pop_front();
          check(mon_e.name, 32'(mon_s), 32'(mon_e.snap));
          if (mon_e.gap >= 0) check({mon_e.name, "_gap"}, 32'(cyc - last_cyc), 32'(mon_e.gap));
        end
        last_cyc = cyc;
        prev = mon_s;
      end
    end
  end
  task automatic model_frame(input logic [2:0] hdr, input logic [1:0] g1, input logic [2:0] g2, input bit pbad);
    bit ok;
    ok = (hdr == 3'b101) && !(PAR && pbad);
    if (m_phase == 1) return;
    if (!ok) begin
      m_err = 1'b1;
      push("err_pulse", -1);
      m_err = 1'b0;
      push("err_end", 1);
    end else if (m_phase == 0) begin
      m_g1 = g1;
      m_g2 = g2;
      m_ready = 1'b0;
      push("latch", -1);
      m_vco = 1'b1;
      push("vco_release", DLY);
      m_r1 = 1'b1;
      push("r1_release", DLY);
      m_r2 = 1'b1;
      m_ready = 1'b1;
      push("r2_release", DLY);
      m_phase = 1;
    end else if ({g1, g2} != {m_g1, m_g2}) begin
      m_g1 = g1;
      m_g2 = g2;
      push("run_gain", -1);
    end
  endtask
  task automatic send_bits(input logic [8:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_sdin = w[FW-1-i];
      @(negedge clk);
      bus.i_sclk = 1'b1;
      repeat (2) @(negedge clk);
      bus.i_sclk = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic send_frame(input logic [2:0] hdr, input logic [1:0] g1, input logic [2:0] g2, input bit pbad);
    logic [8:0] w;
    w = PAR ? {hdr, g1, g2, (~^{hdr, g1, g2}) ^ pbad} : {1'b0, hdr, g1, g2};
    model_frame(hdr, g1, g2, pbad);
    send_bits(w, FW);
    repeat (4) @(negedge clk);
  endtask
  task automatic send_partial(input int n);
    send_bits(9'($urandom), n);
    repeat (70) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    q.delete();
    {m_err, m_ready, m_vco, m_r1, m_r2, m_g1, m_g2} = '0;
    m_phase = 0;
    push("reset", -1);
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'(dut_snap()), 32'(0));
    m_ready = 1'b1;
    push("ready_up", -1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    bus.i_sclk = 1'b0;
    bus.i_sdin = 1'b0;
    {m_err, m_ready, m_vco, m_r1, m_r2, m_g1, m_g2} = '0;
    repeat (3) @(negedge clk);
    check("reset_values", 32'(dut_snap()), 32'(0));
    mon_on = 1'b1;
    m_ready = 1'b1;
    push("ready_up", -1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_first_edge", 32'(bus.o_ready), 32'(1));
    repeat (3) @(negedge clk);
    send_frame(3'b111, 2'b01, 3'b001, 1'b0);
    send_partial(5);
    send_frame(3'b101, 2'b10, 3'b011, 1'b0);
    repeat (60) @(negedge clk);
    m_phase = 2;
    send_frame(3'b101, 2'b11, 3'b100, 1'b0);
    send_partial(3);
    send_frame(3'b101, 2'b01, 3'b111, 1'b0);
    send_frame(3'b010, 2'b00, 3'b000, 1'b0);
    send_frame(3'b101, 2'b10, 3'b011, 1'b1);
    do_reset();
    send_frame(3'b101, 2'b10, 3'b011, 1'b0);
    repeat (20) @(negedge clk);
    check("vco_before_reset", 32'(bus.o_resetbvco), 32'(1));
    check("r1_before_reset", 32'(bus.o_resetb1), 32'(0));
    do_reset();
    send_frame(3'b101, 2'b01, 3'b110, 1'b0);
    repeat (60) @(negedge clk);
    m_phase = 2;
    for (int it = 0; it < 40; it++) begin
      int r;
      logic [2:0] hdr;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        do_reset();
      end else begin
        if (r < 3) send_partial(int'($urandom_range(1, FW - 1)));
        hdr = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b101;
        send_frame(hdr, 2'($urandom), 3'($urandom), $urandom_range(0, 4) == 0);
        if (m_phase == 1) begin
          if ($urandom_range(0, 1) == 1)
            send_frame(3'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
          repeat (60) @(negedge clk);
          m_phase = 2;
        end
      end
    end
    repeat (10) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/backend_seq_ctrl.md
Name: backend_seq_ctrl

Overview:
- Configuration and power-up sequencer for the receive backend.
- Deserialises a gain configuration frame from the FPGA serial link (i_sclk/i_sdin, sampled in the i_clk domain) and drives the gain buses.
- Releases the VCO, stage-1 and stage-2 resets in a fixed, timed order.
- Reports readiness to the FPGA on o_ready.

Parameters:
- DLY_CYC, 16: i_clk cycles between successive reset releases (valid range 1..255).
- GAP_CYC, 64: idle i_clk cycles without an i_sclk rising edge after which a partial frame is discarded.
- FRAME_W, 8: frame length in bits (9 when BACKEND_SEQ_PARITY_EN is defined; not user-overridable).

Ports:
- i_clk  in  1  main clock; all logic on rising edge
- i_resetbAll  in  1  asynchronous, active-low reset
- i_sclk  in  1  serial clock from FPGA, asynchronous to i_clk
- i_sdin  in  1  serial data, MSB first, valid at i_sclk rising edge
- o_ready  out  1  high while a frame will be accepted
- o_gainA1  out  2  stage-1 gain
- o_gainA2  out  3  stage-2 gain
- o_resetbvco  out  1  VCO reset, active-low
- o_resetb1  out  1  stage-1 reset, active-low
- o_resetb2  out  1  stage-2 reset, active-low
- o_frame_err  out  1  one-cycle pulse on a rejected frame

Behaviour:
- Reset values: o_ready=0, o_gainA1=2'b00, o_gainA2=3'b000, o_resetbvco=0, o_resetb1=0, o_resetb2=0, o_frame_err=0.
- Internal reset values: state=WAIT_CFG, counters cleared, shift register cleared.
- Reset assertion at any time, including mid-sequence or mid-frame, returns the block immediately to these values.
- o_ready goes to 1 on the first i_clk edge after reset release.

Input synchronisation:
- i_sclk and i_sdin each pass through a 2-flop synchroniser.
- A third flop on sclk detects the rising edge (sclk_rise).
- On sclk_rise, the synchronised sdin is shifted into the LSB and the bit counter increments.

Frame format (8 bits, MSB first):
- [7:5] header = 3'b101
- [4:3] gainA1
- [2:0] gainA2

Frame completion:
- frame_done fires in the cycle the bit counter reaches FRAME_W.
- The bit counter clears in that same cycle.
- Frame is valid when the header matches and the block is in WAIT_CFG or RUN.
- Header mismatch: o_frame_err pulses high for 1 cycle, the frame is discarded, and state is unchanged.
- Frame completing in SEQ_VCO, SEQ_1 or SEQ_2: discarded silently, no error pulse.

Gap timeout:
- The gap counter counts cycles without sclk_rise.
- On reaching GAP_CYC, the bit counter clears and the partial frame is dropped. No error pulse.
- sclk_rise clears the gap counter.

Latency:
- Last i_sclk rising edge to frame_done: 3 i_clk cycles.
- Gains register on the cycle after frame_done.

State machine:
- WAIT_CFG:
  - o_ready=1.
  - Valid frame: latch gains, load the delay counter with DLY_CYC-1, go to SEQ_VCO, o_ready=0.
- SEQ_VCO:
  - The delay counter decrements each cycle.
  - When it reaches 0: o_resetbvco<=1, reload the counter, go to SEQ_1.
- SEQ_1: same timing as SEQ_VCO; on expiry o_resetb1<=1, go to SEQ_2.
- SEQ_2: same timing; on expiry o_resetb2<=1, o_ready<=1, go to RUN.
- RUN:
  - o_ready=1.
  - Valid frame updates the gains only. The resets stay released and are not resequenced.
- Release cadence: resets release exactly DLY_CYC, 2*DLY_CYC and 3*DLY_CYC cycles after the gain-latch cycle.
- Simultaneous events: frame_done and gap expiry in the same cycle — frame_done wins.
- Gains change only in the cycle after a valid frame_done. No glitch on the gain outputs.

Optional Feature:
- Macro: BACKEND_SEQ_PARITY_EN.
- Defined:
  - FRAME_W=9; bit 0 is an odd-parity bit over bits [8:1].
  - A frame passes only when the header matches and parity is odd.
  - A parity failure is treated like a header mismatch: o_frame_err pulses and the frame is discarded.
  - The payload shifts up by one bit: header [8:6], gainA1 [5:4], gainA2 [3:1].
- Undefined: 8-bit frame, no parity check.

Test Plan:
- Frame 8'b101_10_011 after reset, DLY_CYC=16 -> gainA1=2'b10, gainA2=3'b011 on frame_done+1; resetbvco rises 16 cycles later, resetb1 at 32, resetb2 and o_ready at 48; o_ready=0 in between.
- Frame 8'b111_01_001 in WAIT_CFG -> single-cycle o_frame_err; gains stay 0; o_ready stays 1; no reset released.
- Five bits clocked in, then 70 cycles idle, then valid frame 8'b101_01_111 -> only the second frame is decoded: gainA1=2'b01, gainA2=3'b111.
- In RUN, send frame 8'b101_11_100 -> gains become 2'b11/3'b100; all resets stay 1; o_ready stays 1.
- Assert i_resetbAll during SEQ_1 (resetbvco=1) -> all outputs return to reset values asynchronously; the next valid frame restarts the full sequence.
- With BACKEND_SEQ_PARITY_EN: 9'b101_10_011_0 (bits [8:1] have an odd count of ones, so parity 0 makes the frame odd) -> accepted; 9'b101_10_011_1 -> o_frame_err pulse, gains unchanged.
